// File: rtl/nx_ram_1rw_indirect_access_v3.sv
// Single-port RAM shared between a hardware client and a CSR-driven software command channel.
// Software gets READ/WRITE/INIT commands; a starvation timer forces hardware to yield to it.
module nx_ram_1rw_indirect_access_v3 #(
    parameter int                         N_REG_ADDR_BITS = 11,
    parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS    = 11'h1B8,
    parameter int                         N_DATA_BITS     = 38,
    parameter int                         N_ENTRIES       = 16384,
    parameter int                         RD_LATENCY      = 1,
    parameter int                         N_TIMER_BITS    = 6,
    parameter logic [15:0]                CAPABILITIES    = 16'hC17F,
    localparam int                        ADDR_W          = $clog2(N_ENTRIES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REG_ADDR_BITS-1:0] reg_addr,
    input  logic                       wr_stb,
    input  logic [3:0]                 cmnd_op,
    input  logic [ADDR_W:0]            cmnd_addr,
    input  logic [N_DATA_BITS-1:0]     wr_dat,
    output logic [2:0]                 stat_code,
    output logic [4:0]                 stat_datawords,
    output logic [ADDR_W-1:0]          stat_addr,
    output logic [15:0]                capability_lst,
    output logic [N_DATA_BITS-1:0]     rd_dat,
    input  logic [ADDR_W-1:0]          hw_add,
    input  logic                       hw_we,
    input  logic [N_DATA_BITS-1:0]     hw_bwe,
    input  logic                       hw_cs,
    input  logic [N_DATA_BITS-1:0]     hw_din,
    output logic [N_DATA_BITS-1:0]     hw_dout,
    output logic                       hw_yield
);

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_ERR_OP   = 3'd1;
    localparam logic [2:0] ST_ERR_ADDR = 3'd2;
    localparam logic [2:0] ST_BUSY     = 3'd3;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_READ    = 4'd1;
    localparam logic [3:0] OP_WRITE   = 4'd2;
    localparam logic [3:0] OP_ENABLE  = 4'd3;
    localparam logic [3:0] OP_DISABLE = 4'd4;
    localparam logic [3:0] OP_INIT    = 4'd5;

    localparam logic [ADDR_W:0]         ENTRIES_W = (ADDR_W+1)'(N_ENTRIES);
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_ENTRIES - 1);
    localparam logic [N_TIMER_BITS-1:0] TIMER_MAX = '1;
    localparam logic                    RD_LAST   = 1'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        SW_REQ,
        RD_WAIT,
        INIT_RUN
    } state_t;

    state_t                   state, state_n;
    logic [2:0]               stat_q, stat_n;
    logic [ADDR_W-1:0]        stat_addr_q, stat_addr_n;
    logic [N_DATA_BITS-1:0]   rd_dat_q, rd_dat_n;
    logic                     enable_q, enable_n;
    logic [3:0]               op_q, op_n;
    logic [ADDR_W-1:0]        sw_addr_q, sw_addr_n;
    logic [N_DATA_BITS-1:0]   sw_data_q, sw_data_n;
    logic                     rd_cnt, rd_cnt_n;
    logic [N_TIMER_BITS-1:0]  starve_cnt;

    logic [N_DATA_BITS-1:0]   mem [N_ENTRIES];
    logic [N_DATA_BITS-1:0]   rd_pipe [RD_LATENCY];
    logic [RD_LATENCY-1:0]    hv_pipe;
    logic [N_DATA_BITS-1:0]   hold_q;
    logic [N_DATA_BITS-1:0]   hw_out;

    logic              launch, cmd_is_mem, cmd_oor;
    logic              sw_pending, sw_grant, hw_req, hw_grant, sat;
    logic              sw_we, hw_wr;
    logic [ADDR_W-1:0] port_addr;

    assign launch     = wr_stb && (reg_addr == CMND_ADDRESS) && (state == IDLE);
    assign cmd_is_mem = (cmnd_op == OP_READ) || (cmnd_op == OP_WRITE) || (cmnd_op == OP_INIT);
    assign cmd_oor    = (cmnd_addr >= ENTRIES_W);

    // One access per cycle: a saturated timer hands the slot to software and drops hardware.
    assign sat        = (starve_cnt == TIMER_MAX);
    assign sw_pending = (state == SW_REQ) || (state == INIT_RUN);
    assign hw_req     = hw_cs && enable_q;
    assign sw_grant   = sw_pending && (!hw_req || sat);
    assign hw_grant   = hw_req && !sw_grant;
    assign hw_yield   = hw_cs && !hw_grant;
    assign sw_we      = sw_grant && ((state == INIT_RUN) || (op_q == OP_WRITE));
    assign hw_wr      = hw_grant && hw_we;
    assign port_addr  = sw_grant ? sw_addr_q : hw_add;

    always_comb begin
        state_n     = state;
        stat_n      = stat_q;
        stat_addr_n = stat_addr_q;
        rd_dat_n    = rd_dat_q;
        enable_n    = enable_q;
        op_n        = op_q;
        sw_addr_n   = sw_addr_q;
        sw_data_n   = sw_data_q;
        rd_cnt_n    = rd_cnt;
        case (state)
            IDLE: begin
                if (launch) begin
                    if (cmnd_op > OP_INIT) begin
                        stat_n = ST_ERR_OP;
                    end else if (cmd_is_mem && cmd_oor) begin
                        stat_n = ST_ERR_ADDR;
                    end else if (cmnd_op == OP_NOP) begin
                        stat_n = ST_OK;
                    end else if (cmnd_op == OP_ENABLE || cmnd_op == OP_DISABLE) begin
                        enable_n = (cmnd_op == OP_ENABLE);
                        stat_n   = ST_OK;
                    end else begin
                        stat_n      = ST_BUSY;
                        stat_addr_n = cmnd_addr[ADDR_W-1:0];
                        sw_addr_n   = cmnd_addr[ADDR_W-1:0];
                        sw_data_n   = wr_dat;
                        op_n        = cmnd_op;
                        state_n     = (cmnd_op == OP_INIT) ? INIT_RUN : SW_REQ;
                    end
                end
            end
            SW_REQ: begin
                if (sw_grant) begin
                    if (op_q == OP_READ) begin
                        rd_cnt_n = 1'b0;
                        state_n  = RD_WAIT;
                    end else begin
                        stat_n  = ST_OK;
                        state_n = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                if (rd_cnt == RD_LAST) begin
                    rd_dat_n = rd_pipe[RD_LATENCY-1];
                    stat_n   = ST_OK;
                    state_n  = IDLE;
                end else begin
                    rd_cnt_n = 1'b1;
                end
            end
            INIT_RUN: begin
                if (sw_grant) begin
                    stat_addr_n = sw_addr_q;
                    if (sw_addr_q == LAST_ADDR) begin
                        stat_n  = ST_OK;
                        state_n = IDLE;
                    end else begin
                        sw_addr_n = sw_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            stat_q      <= ST_OK;
            stat_addr_q <= '0;
            rd_dat_q    <= '0;
            enable_q    <= 1'b1;
            op_q        <= OP_NOP;
            sw_addr_q   <= '0;
            sw_data_q   <= '0;
            rd_cnt      <= 1'b0;
        end else begin
            state       <= state_n;
            stat_q      <= stat_n;
            stat_addr_q <= stat_addr_n;
            rd_dat_q    <= rd_dat_n;
            enable_q    <= enable_n;
            op_q        <= op_n;
            sw_addr_q   <= sw_addr_n;
            sw_data_q   <= sw_data_n;
            rd_cnt      <= rd_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (sw_grant) begin
            starve_cnt <= '0;
        end else if (sw_pending && hw_grant && !sat) begin
            starve_cnt <= starve_cnt + N_TIMER_BITS'(1);
        end
    end

    // Array contents survive reset; writes are blocked on the reset edge itself.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (sw_we) begin
                mem[sw_addr_q] <= sw_data_q;
            end else if (hw_wr) begin
                mem[hw_add] <= (mem[hw_add] & ~hw_bwe) | (hw_din & hw_bwe);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= '0;
            end
            hv_pipe <= '0;
            hold_q  <= '0;
        end else begin
            rd_pipe[0] <= mem[port_addr];
            hv_pipe[0] <= hw_grant && !hw_we;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
                hv_pipe[i] <= hv_pipe[i-1];
            end
            hold_q <= hw_out;
        end
    end

    // A hardware read result appears exactly RD_LATENCY cycles after its grant and is then held.
    assign hw_out = hv_pipe[RD_LATENCY-1] ? rd_pipe[RD_LATENCY-1] : hold_q;
    assign hw_dout = enable_q ? hw_out : '0;

    assign stat_code      = stat_q;
    assign stat_addr      = stat_addr_q;
    assign rd_dat         = rd_dat_q;
    assign stat_datawords = 5'((N_DATA_BITS + 31) / 32);
    assign capability_lst = CAPABILITIES;

endmodule

// File: tb/tb_nx_ram_1rw_indirect_access_v3.sv
// Directed plus randomized checks of the shared-port RAM against an array model of its contents.
module tb_nx_ram_1rw_indirect_access_v3;
    localparam int DW  = 38;
    localparam int NE  = 1024;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int TMB = 3;
    localparam logic [10:0] CMND = 11'h1B8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   reg_addr = '0;
    logic          wr_stb = 1'b0;
    logic [3:0]    cmnd_op = '0;
    logic [AW:0]   cmnd_addr = '0;
    logic [DW-1:0] wr_dat = '0;
    logic [2:0]    stat_code;
    logic [4:0]    stat_datawords;
    logic [AW-1:0] stat_addr;
    logic [15:0]   capability_lst;
    logic [DW-1:0] rd_dat;
    logic [AW-1:0] hw_add = '0;
    logic          hw_we = 1'b0;
    logic [DW-1:0] hw_bwe = '0;
    logic          hw_cs = 1'b0;
    logic [DW-1:0] hw_din = '0;
    logic [DW-1:0] hw_dout;
    logic          hw_yield;

    nx_ram_1rw_indirect_access_v3 #(
        .N_REG_ADDR_BITS(11), .CMND_ADDRESS(CMND), .N_DATA_BITS(DW), .N_ENTRIES(NE),
        .RD_LATENCY(LAT), .N_TIMER_BITS(TMB), .CAPABILITIES(16'hC17F)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .wr_stb(wr_stb), .cmnd_op(cmnd_op),
        .cmnd_addr(cmnd_addr), .wr_dat(wr_dat), .stat_code(stat_code),
        .stat_datawords(stat_datawords), .stat_addr(stat_addr), .capability_lst(capability_lst),
        .rd_dat(rd_dat), .hw_add(hw_add), .hw_we(hw_we), .hw_bwe(hw_bwe), .hw_cs(hw_cs),
        .hw_din(hw_din), .hw_dout(hw_dout), .hw_yield(hw_yield)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] ref_mem [NE];
    logic [DW-1:0] last_hw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return DW'({$urandom(), $urandom()});
    endfunction

    // All tasks are entered shortly after a rising edge and return the same way.
    task automatic sw_launch(input logic [3:0] op, input logic [AW:0] a, input logic [DW-1:0] d);
        reg_addr = CMND; wr_stb = 1'b1; cmnd_op = op; cmnd_addr = a; wr_dat = d;
        @(posedge clk); #1;
        wr_stb = 1'b0; cmnd_op = 4'd0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (stat_code == 3'd3 && cyc < budget);
        check({tag, "_done"}, 64'(stat_code), 64'd0);
    endtask

    task automatic sw_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int cyc;
        sw_launch(4'd2, {1'b0, a}, d);
        check("sw_wr_busy", 64'(stat_code), 64'd3);
        wait_done("sw_wr", 20, cyc);
        check("sw_wr_cycles", 64'(cyc), 64'd1);
        ref_mem[a] = d;
    endtask

    task automatic sw_read(input logic [AW-1:0] a);
        int cyc;
        sw_launch(4'd1, {1'b0, a}, '0);
        check("sw_rd_busy", 64'(stat_code), 64'd3);
        wait_done("sw_rd", 20, cyc);
        check("sw_rd_cycles", 64'(cyc), 64'(1 + LAT));
        check("sw_rd_data", 64'(rd_dat), 64'(ref_mem[a]));
        check("sw_rd_addr", 64'(stat_addr), 64'(a));
    endtask

    task automatic hw_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] be);
        hw_cs = 1'b1; hw_we = 1'b1; hw_add = a; hw_din = d; hw_bwe = be;
        #1 check("hw_wr_yield", 64'(hw_yield), 64'd0);
        @(posedge clk); #1;
        hw_cs = 1'b0; hw_we = 1'b0;
        ref_mem[a] = (ref_mem[a] & ~be) | (d & be);
    endtask

    task automatic hw_read(input logic [AW-1:0] a, input bit chk_early);
        hw_cs = 1'b1; hw_we = 1'b0; hw_add = a;
        #1 check("hw_rd_yield", 64'(hw_yield), 64'd0);
        @(posedge clk); #1;
        hw_cs = 1'b0;
        if (chk_early) check("hw_rd_early", 64'(hw_dout), 64'(last_hw));
        @(posedge clk); #1;
        check("hw_rd_data", 64'(hw_dout), 64'(ref_mem[a]));
        @(posedge clk); #1;
        check("hw_rd_hold", 64'(hw_dout), 64'(ref_mem[a]));
        last_hw = ref_mem[a];
    endtask

    initial begin
        int cyc;
        logic [DW-1:0] d0, d2, v;
        logic [AW-1:0] a, b, r;

        // reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_stat", 64'(stat_code), 64'd0);
        check("rst_addr", 64'(stat_addr), 64'd0);
        check("rst_rd_dat", 64'(rd_dat), 64'd0);
        check("rst_hw_dout", 64'(hw_dout), 64'd0);
        check("rst_yield", 64'(hw_yield), 64'd0);
        check("datawords", 64'(stat_datawords), 64'd2);
        check("caps", 64'(capability_lst), 64'hC17F);
        last_hw = '0;

        // fill whole array so every later read has a known value
        d0 = rnd_word();
        sw_launch(4'd5, 11'd0, d0);
        check("init_busy", 64'(stat_code), 64'd3);
        wait_done("init_all", 1100, cyc);
        check("init_all_cycles", 64'(cyc), 64'(NE));
        check("init_all_addr", 64'(stat_addr), 64'(NE - 1));
        for (int i = 0; i < NE; i++) ref_mem[i] = d0;

        // write then read
        sw_write(10'd5, 38'h2A_5555_AAAA);
        sw_read(10'd5);
        check("wr_rd_value", 64'(rd_dat), 64'h2A_5555_AAAA);

        // hardware read latency
        hw_write(10'd9, 38'h1, '1);
        hw_write(10'd8, 38'h3F_0000_1234, '1);
        hw_read(10'd8, 1'b1);
        hw_read(10'd9, 1'b1);

        // starvation on a software READ with hardware reading continuously
        r = 10'd8; a = 10'd5;
        hw_cs = 1'b1; hw_we = 1'b0; hw_add = r;
        sw_launch(4'd1, {1'b0, a}, '0);
        for (int k = 1; k <= 8; k++) begin
            check("starve_rd_yield", 64'(hw_yield), 64'(k == 8));
            @(posedge clk); #1;
        end
        check("starve_rd_after", 64'(hw_yield), 64'd0);
        wait_done("starve_rd", 10, cyc);
        check("starve_rd_after2", 64'(hw_yield), 64'd0);
        check("starve_rd_data", 64'(rd_dat), 64'(ref_mem[a]));
        hw_cs = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        last_hw = ref_mem[r];

        // starvation on a software WRITE; the hardware write in the yielded cycle is lost
        a = 10'd20; b = 10'd21; v = rnd_word();
        hw_cs = 1'b1; hw_we = 1'b1; hw_add = b; hw_bwe = '1; hw_din = '0;
        sw_launch(4'd2, {1'b0, a}, v);
        for (int k = 1; k <= 8; k++) begin
            hw_din = DW'(k);
            #1 check("starve_wr_yield", 64'(hw_yield), 64'(k == 8));
            @(posedge clk); #1;
        end
        hw_cs = 1'b0; hw_we = 1'b0;
        check("starve_wr_stat", 64'(stat_code), 64'd0);
        ref_mem[a] = v;
        ref_mem[b] = DW'(7);
        hw_read(b, 1'b1);
        sw_read(a);

        // INIT boundary
        v = rnd_word();
        hw_write(10'd1019, v, '1);
        sw_launch(4'd5, 11'd1020, DW'(7));
        wait_done("init_tail", 20, cyc);
        check("init_tail_cycles", 64'(cyc), 64'd4);
        check("init_tail_addr", 64'(stat_addr), 64'd1023);
        for (int i = 1020; i < NE; i++) ref_mem[i] = DW'(7);
        sw_read(10'd1019);
        sw_read(10'd1023);
        sw_read(10'd1020);

        // errors and control ops
        sw_launch(4'hF, 11'd3, '0);
        check("err_op", 64'(stat_code), 64'd1);
        check("err_op_addr", 64'(stat_addr), 64'd1020);
        sw_launch(4'd1, 11'd1024, '0);
        check("err_addr_rd", 64'(stat_code), 64'd2);
        sw_launch(4'd5, 11'd1500, '0);
        check("err_addr_init", 64'(stat_code), 64'd2);
        check("err_addr_stat_addr", 64'(stat_addr), 64'd1020);
        sw_launch(4'd0, 11'd0, '0);
        check("nop_ok", 64'(stat_code), 64'd0);

        sw_launch(4'd4, 11'd0, '0);
        check("disable_ok", 64'(stat_code), 64'd0);
        hw_cs = 1'b1; hw_we = 1'b0; hw_add = 10'd9;
        #1 check("dis_yield", 64'(hw_yield), 64'd1);
        check("dis_dout", 64'(hw_dout), 64'd0);
        hw_we = 1'b1; hw_add = 10'd30; hw_din = ~ref_mem[30]; hw_bwe = '1;
        @(posedge clk); #1;
        check("dis_wr_yield", 64'(hw_yield), 64'd1);
        hw_cs = 1'b0; hw_we = 1'b0;
        sw_launch(4'd3, 11'd0, '0);
        check("enable_ok", 64'(stat_code), 64'd0);
        hw_read(10'd30, 1'b0);

        // reset in the middle of an INIT; a strobe while busy is ignored
        d2 = rnd_word();
        sw_launch(4'd5, 11'd100, d2);
        reg_addr = CMND; wr_stb = 1'b1; cmnd_op = 4'hF;
        @(posedge clk); #1;
        wr_stb = 1'b0; cmnd_op = 4'd0;
        check("busy_ignore", 64'(stat_code), 64'd3);
        check("init_track0", 64'(stat_addr), 64'd100);
        @(posedge clk); #1;
        check("init_track1", 64'(stat_addr), 64'd101);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_mem[100] = d2; ref_mem[101] = d2;
        last_hw = '0;
        check("mid_rst_stat", 64'(stat_code), 64'd0);
        check("mid_rst_addr", 64'(stat_addr), 64'd0);
        check("mid_rst_dout", 64'(hw_dout), 64'd0);
        sw_read(10'd102);
        sw_read(10'd101);
        sw_read(10'd100);

        // randomized traffic, one operation at a time
        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom_range(0, NE - 1));
            case ($urandom_range(0, 3))
                0: hw_write(a, rnd_word(), rnd_word());
                1: hw_read(a, 1'b1);
                2: sw_write(a, rnd_word());
                default: sw_read(a);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/nx_ram_1rw_indirect_access_v3.md
Name: nx_ram_1rw_indirect_access_v3

Overview:
- Parametrised successor to the single-port indirect-access RAM wrapper.
- Contains a behavioural 1RW array that is shared between a hardware client and a software register-command channel.
- New over the prior generation:
  - configurable width, depth and read latency;
  - range INIT (fill) command;
  - starvation timer that forces hardware to yield to a pending software access;
  - explicit address-range and opcode error reporting.
- Sits inside engine memory subsystems, behind the CSR decoder.

Parameters:
- CMND_ADDRESS, 11'h1B8, register address that launches a command.
- N_REG_ADDR_BITS, 11, width of reg_addr.
- N_DATA_BITS, 38, RAM word width (1..256).
- N_ENTRIES, 16384, RAM depth; ADDR_W = $clog2(N_ENTRIES).
- RD_LATENCY, 1, array read latency in cycles (1 or 2).
- N_TIMER_BITS, 6, width of the starvation counter.
- CAPABILITIES, 16'hC17F, value driven on capability_lst.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- reg_addr  in  N_REG_ADDR_BITS  CSR write address.
- wr_stb  in  1  CSR write strobe.
- cmnd_op  in  4  opcode: 0 NOP, 1 READ, 2 WRITE, 3 ENABLE, 4 DISABLE, 5 INIT.
- cmnd_addr  in  ADDR_W+1  command address (the extra bit allows out-of-range detection).
- wr_dat  in  N_DATA_BITS  write/fill data.
- stat_code  out  3  0 OK, 1 ERR_OP, 2 ERR_ADDR, 3 BUSY.
- stat_datawords  out  5  ceil(N_DATA_BITS/32), constant.
- stat_addr  out  ADDR_W  address of last command / last INIT entry written.
- capability_lst  out  16  CAPABILITIES.
- rd_dat  out  N_DATA_BITS  software read result.
- hw_add  in  ADDR_W  hardware address.
- hw_we  in  1  hardware write.
- hw_bwe  in  N_DATA_BITS  hardware bit write enables.
- hw_cs  in  1  hardware request.
- hw_din  in  N_DATA_BITS  hardware write data.
- hw_dout  out  N_DATA_BITS  hardware read data.
- hw_yield  out  1  hardware request not served this cycle.

Behaviour:
- Reset: synchronous on rst_n=0 at posedge clk. Resulting state:
  - FSM in IDLE; stat_code=0; stat_addr=0; rd_dat=0; hw_dout=0; hw_yield=0;
  - enable=1; starvation counter=0;
  - array contents are not cleared.
- Reset mid-command aborts the command. No further array writes occur after the reset edge.

Command launch:
- A command is launched on wr_stb && reg_addr==CMND_ADDRESS while the FSM is in IDLE.
- Launch strobes received while not in IDLE are ignored and do not change status.

Launch checks:
- Opcode above 5: stat_code=ERR_OP, no access, stays IDLE.
- READ, WRITE or INIT with cmnd_addr >= N_ENTRIES: stat_code=ERR_ADDR, no access.
- NOP: stat_code=OK.
- ENABLE or DISABLE: sets/clears enable next cycle; stat_code=OK.
- READ, WRITE or INIT: stat_code=BUSY; stat_addr=cmnd_addr.

FSM states:
- IDLE: transitions on launch as described above.
- SW_REQ: waits for a port slot, then issues the access.
  - WRITE writes the full word; all bit enables are set.
  - READ goes to RD_WAIT; WRITE completes and returns to IDLE with stat_code=OK.
- RD_WAIT: counts RD_LATENCY cycles, then captures the array output into rd_dat, sets stat_code=OK, returns to IDLE.
- INIT_RUN:
  - Writes wr_dat (latched at launch) to one entry per granted slot, from cmnd_addr up to N_ENTRIES-1.
  - stat_addr tracks the entry just written.
  - After writing N_ENTRIES-1, stat_code=OK and return to IDLE. No wrap to 0.

Port arbitration (per cycle):
- hw_cs && enable wins unless the starvation counter is saturated.
- Software is granted when hardware is not requesting, or when the counter is saturated.
- When software is pending and hardware wins, the counter increments (saturating at 2^N_TIMER_BITS-1).
- When the counter is saturated:
  - software is granted that cycle;
  - hw_yield=1 combinationally if hw_cs=1;
  - the hardware access is dropped;
  - the counter clears.
- The counter clears on any software grant. Hardware must re-present a yielded request.

Hardware accesses:
- Hardware access with enable=0: ignored; hw_yield=1 while hw_cs; hw_dout=0.
- Hardware read: hw_dout is valid exactly RD_LATENCY cycles after the granted cycle and holds until the next hardware read result.
- Hardware write: applies hw_bwe per bit.

Concurrency:
- Software INIT/WRITE and a hardware access never touch the array in the same cycle. One port, one access per cycle.

Test Plan:
- Write then read: WRITE addr 5, wr_dat=38'h2A_5555_AAAA, then READ addr 5 with hw_cs=0 -> stat_code BUSY, then OK; rd_dat=38'h2A_5555_AAAA; stat_addr=5.
- Hardware read latency: hw write addr 9 = 38'h1, then hw read addr 9 (RD_LATENCY=2) -> hw_dout=38'h1 exactly 2 cycles after the request; hw_yield=0.
- Starvation: N_TIMER_BITS=3, hw_cs held high, READ launched -> hw_yield=1 for one cycle at the 8th SW_REQ cycle; READ completes; hw_yield=0 afterwards.
- INIT boundary: N_ENTRIES=1024, INIT from 1020 with data 7, no hw traffic -> 4 writes (1020..1023), stat_addr=1023, stat_code OK. Reading 1019 returns its old value.
- Errors: cmnd_op=4'hF -> ERR_OP. READ addr 1024 (N_ENTRIES=1024) -> ERR_ADDR. DISABLE then hw read -> hw_yield=1, hw_dout=0.
- Reset mid-INIT: rst_n=0 for 1 cycle after 2 INIT writes -> stat_code=0, FSM idle, no further entries written, a new command is accepted next cycle.
